boot_loader: RTL

Program-load sequencer for the 32-word bootstrap ROM.
- On a front-panel PROGRAM LOAD request it holds the CPU and copies ROM words 0..31 into core memory locations BOOT_BASE..BOOT_BASE+31.
- It then loads the PC with START_ADDR and releases the CPU to run.
- Sits between the front-panel logic, the bootstrap ROM (combinational read: rom_addr in, rom_YD out) and the core-memory port, which it shares with the CPU while the CPU is held.

---
 rtl/boot_loader_if.sv | 28 ++
 rtl/boot_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/boot_loader_if.sv
`timescale 1ns/1ps
// Core-memory write port shared between the boot loader and the CPU.
// The loader drives the request side; the memory answers with a one-cycle ack.
interface boot_loader_if #(
  parameter int ADDR_W = 15
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/boot_loader.sv
`timescale 1ns/1ps
// Program-load sequencer: on a front-panel PROGRAM LOAD request it holds the
// CPU, copies the bootstrap ROM into core memory, loads the PC and restarts
// the CPU. All outputs except rom_addr are registered; rom_addr follows the
// word counter so the combinational ROM presents the word during READ.
module boot_loader #(
  parameter int ADDR_W     = 15,
  parameter int BOOT_BASE  = 0,
  parameter int BOOT_LEN   = 32,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_req,
  input  logic              cpu_halted,
  output logic [4:0]        rom_addr,
  input  logic [15:0]       rom_YD,
  output logic              cpu_hold,
  boot_loader_if.master     mem,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              run_start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    SETPC = 3'd4,
    GO    = 3'd5
  } state_t;

  // Index of the final word; the copy stops here so the 5-bit counter never wraps.
  localparam logic [4:0]        LAST_WORD = 5'(BOOT_LEN - 1);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(START_ADDR);

  state_t              state;
  state_t              state_n;
  logic [4:0]          cnt;
  logic [4:0]          cnt_n;
  logic                cpu_hold_n;
  logic                busy_n;
  logic                req_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [15:0]         wdata_n;
  logic                pc_load_n;
  logic [ADDR_W-1:0]   pc_value_n;
  logic                run_start_n;
  logic                done_n;
  logic                ack_seen;

  // Destination address for ROM word idx, wrapped to the core address width.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [4:0] idx);
    logic [ADDR_W+5:0] sum;
    sum = (ADDR_W+6)'(BOOT_BASE) + (ADDR_W+6)'(idx);
    return sum[ADDR_W-1:0];
  endfunction

  assign rom_addr = cnt;

  // An ack only counts while our own request is up; stray acks are ignored.
  assign ack_seen = mem.mem_req & mem.mem_ack;

  // Next-state and next-output decode; registered values hold unless changed.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cpu_hold_n  = cpu_hold;
    busy_n      = busy;
    req_n       = mem.mem_req;
    addr_n      = mem.mem_addr;
    wdata_n     = mem.mem_wdata;
    pc_load_n   = 1'b0;
    pc_value_n  = pc_value;
    run_start_n = 1'b0;
    done_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pl_req) begin
          state_n    = HOLD;
          cpu_hold_n = 1'b1;
          busy_n     = 1'b1;
        end
      end
      HOLD: begin
        if (cpu_halted) begin
          state_n = READ;
        end
      end
      READ: begin
        addr_n  = word_addr(cnt);
        wdata_n = rom_YD;
        req_n   = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        if (ack_seen) begin
          req_n = 1'b0;
          if (cnt == LAST_WORD) begin
            state_n    = SETPC;
            pc_load_n  = 1'b1;
            pc_value_n = START_PC;
          end else begin
            cnt_n   = cnt + 5'd1;
            state_n = READ;
          end
        end
      end
      SETPC: begin
        run_start_n = 1'b1;
        done_n      = 1'b1;
        state_n     = GO;
      end
      GO: begin
        cpu_hold_n = 1'b0;
        busy_n     = 1'b0;
        cnt_n      = 5'd0;
        state_n    = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 16'd0;
      pc_load       <= 1'b0;
      pc_value      <= '0;
      run_start     <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      cpu_hold      <= cpu_hold_n;
      busy          <= busy_n;
      mem.mem_req   <= req_n;
      mem.mem_we    <= req_n;
      mem.mem_addr  <= addr_n;
      mem.mem_wdata <= wdata_n;
      pc_load       <= pc_load_n;
      pc_value      <= pc_value_n;
      run_start     <= run_start_n;
      done          <= done_n;
    end
  end

endmodule
